// File: rtl/map_sst_ctrl_if.sv
// map_sst_ctrl_if: mapper save-state bus plus save/load byte streams
interface map_sst_ctrl_if;
    logic [7:0] sst_addr;
    logic [7:0] sst_dato;
    logic       sst_we;
    logic       sst_act;
    logic [7:0] sst_di;
    logic [7:0] so_data;
    logic       so_valid;
    logic       so_ready;
    logic [7:0] si_data;
    logic       si_valid;
    logic       si_ready;
    modport master (
        output sst_addr, sst_dato, sst_we, sst_act, so_data, so_valid, si_ready,
        input  sst_di, so_ready, si_data, si_valid
    );
    modport slave (
        input  sst_addr, sst_dato, sst_we, sst_act, so_data, so_valid, si_ready,
        output sst_di, so_ready, si_data, si_valid
    );
endinterface

// File: rtl/map_sst_ctrl.sv
// map_sst_ctrl: streams mapper save-state registers out (save) or back in (load)
module map_sst_ctrl #(
    parameter int REG_CNT = 127,
    parameter int RD_LAT  = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start_save,
    input  logic           start_load,
    input  logic [7:0]     exp_map_idx,
    map_sst_ctrl_if.master bus,
    output logic           busy,
    output logic           done,
    output logic           err
);
    typedef enum logic [2:0] {IDLE, S_ADDR, S_WAIT, S_OUT, L_HDR, L_DATA, L_WR, FIN} state_t;
    localparam logic [7:0] HDR_IDX   = 8'(REG_CNT);
    localparam logic [7:0] LAST_IDX  = 8'(REG_CNT - 1);
    localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 1);
    state_t     state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dato_q, dato_d;
    logic [7:0] so_data_q, so_data_d;
    logic [1:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    // state and datapath registers; reset abandons any transfer immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dato_q    <= '0;
            so_data_q <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dato_q    <= dato_d;
            so_data_q <= so_data_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end
    // next-state logic; the header byte is index REG_CNT, then registers 0..REG_CNT-1
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dato_d    = dato_q;
        so_data_d = so_data_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                if (start_save) begin
                    state_d = S_ADDR;
                    idx_d   = HDR_IDX;
                    err_d   = 1'b0;
                end else if (start_load) begin
                    state_d = L_HDR;
                    err_d   = 1'b0;
                end
            end
            S_ADDR: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    so_data_d = bus.sst_di;
                    state_d   = S_OUT;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_OUT: begin
                if (bus.so_ready) begin
                    state_d = (idx_q == LAST_IDX) ? FIN : S_ADDR;
                    idx_d   = (idx_q == LAST_IDX || idx_q == HDR_IDX) ? 8'd0 : idx_q + 8'd1;
                end
            end
            L_HDR: begin
                if (bus.si_valid) begin
                    state_d = (bus.si_data == exp_map_idx) ? L_DATA : FIN;
                    err_d   = (bus.si_data != exp_map_idx);
                    idx_d   = '0;
                end
            end
            L_DATA: begin
                if (bus.si_valid) begin
                    dato_d  = bus.si_data;
                    state_d = L_WR;
                end
            end
            L_WR: begin
                state_d = (idx_q == LAST_IDX) ? FIN : L_DATA;
                idx_d   = (idx_q == LAST_IDX) ? 8'd0 : idx_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.sst_addr = idx_q;
    assign bus.sst_dato = dato_q;
    assign bus.sst_we   = (state_q == L_WR);
    assign bus.sst_act  = (state_q != IDLE);
    assign bus.so_data  = so_data_q;
    assign bus.so_valid = (state_q == S_OUT);
    assign bus.si_ready = (state_q == L_HDR) || (state_q == L_DATA);
    assign busy         = (state_q != IDLE);
    assign done         = (state_q == FIN);
    assign err          = err_q;
endmodule

// File: tb/tb_map_sst_ctrl.sv
// tb_map_sst_ctrl: directed save/load/reset scenarios against mapper models
module tb_map_sst_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ss1 = 1'b0, sl1 = 1'b0, ss3 = 1'b0;
    logic busy1, done1, err1, busy3, done3, err3;
    logic [7:0] p1, p3a, p3b, p3c;
    logic [7:0] mem [0:255];
    int dcnt1 = 0, dcnt3 = 0, wcnt1 = 0;
    int n_checks = 0, n_fail = 0;

    map_sst_ctrl_if bus1();
    map_sst_ctrl_if bus3();

    map_sst_ctrl #(.REG_CNT(127), .RD_LAT(1)) u1 (
        .clk(clk), .rst(rst), .start_save(ss1), .start_load(sl1), .exp_map_idx(8'd24),
        .bus(bus1), .busy(busy1), .done(done1), .err(err1));
    map_sst_ctrl #(.REG_CNT(4), .RD_LAT(3)) u3 (
        .clk(clk), .rst(rst), .start_save(ss3), .start_load(1'b0), .exp_map_idx(8'd24),
        .bus(bus3), .busy(busy3), .done(done3), .err(err3));

    always #5 clk = ~clk;

    // mapper models: 1-stage and 3-stage readback pipelines, write capture
    always @(posedge clk) begin
        p1  <= bus1.sst_addr;
        p3a <= bus3.sst_addr;
        p3b <= p3a;
        p3c <= p3b;
        if (bus1.sst_we) begin
            mem[bus1.sst_addr] <= bus1.sst_dato;
            wcnt1 <= wcnt1 + 1;
        end
        if (done1) dcnt1 <= dcnt1 + 1;
        if (done3) dcnt3 <= dcnt3 + 1;
    end
    assign bus1.sst_di = (p1 == 8'd127) ? 8'd24 : p1 ^ 8'h5A;
    assign bus3.sst_di = (p3c == 8'd4) ? 8'd24 : p3c ^ 8'h5A;

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus1.sst_addr, bus1.sst_dato, bus1.sst_we, bus1.sst_act, bus1.so_data, bus1.so_valid,
             bus1.si_ready, busy1, done1, err1} !== '0) begin
            n_fail++; $display("FAIL reset_u1: outputs not all zero (busy=%b valid=%b addr=%h)", busy1, bus1.so_valid, bus1.sst_addr);
        end
        n_checks++;
        if ({bus3.sst_addr, bus3.so_data, bus3.so_valid, bus3.si_ready, busy3, done3, err3} !== '0) begin
            n_fail++; $display("FAIL reset_u3: outputs not all zero (busy=%b addr=%h)", busy3, bus3.sst_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy1 !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset: busy=%b expected 0", busy1); end
    endtask

    task automatic run_save1(input bit rnd, input bit both);
        int n, cyc, gap, d0;
        logic [7:0] exp_b, held;
        bit pend;
        d0 = dcnt1; ss1 = 1'b1; sl1 = both;
        @(negedge clk);
        ss1 = 1'b0; sl1 = 1'b0;
        n_checks++;
        if (err1 !== 1'b0) begin n_fail++; $display("FAIL save_err_clear: err=%b expected 0", err1); end
        n = 0; cyc = 0; gap = 0; pend = 0;
        while (!done1 && cyc < 3000) begin
            bus1.so_ready = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
            n_checks++;
            if (bus1.si_ready !== 1'b0) begin n_fail++; $display("FAIL si_ready_in_save: got %b expected 0", bus1.si_ready); end
            if (bus1.so_valid) begin
                if (pend) begin
                    n_checks++;
                    if (bus1.so_data !== held) begin n_fail++; $display("FAIL so_data_stable: got %h expected %h", bus1.so_data, held); end
                end
                if (bus1.so_ready) begin
                    exp_b = (n == 0) ? 8'h18 : (8'(n - 1) ^ 8'h5A);
                    n_checks++;
                    if (bus1.so_data !== exp_b) begin n_fail++; $display("FAIL save_byte[%0d]: got %h expected %h", n, bus1.so_data, exp_b); end
                    if (n > 0) begin
                        n_checks++;
                        if (gap !== 2) begin n_fail++; $display("FAIL save_gap[%0d]: got %0d expected 2", n, gap); end
                    end
                    n++; pend = 0; gap = 0;
                end else begin
                    pend = 1; held = bus1.so_data;
                end
            end else begin
                n_checks++;
                if (pend) begin n_fail++; $display("FAIL so_valid_drop: valid fell before handshake at byte %0d", n); end
                gap++;
            end
            @(negedge clk);
            cyc++;
        end
        bus1.so_ready = 1'b0;
        n_checks++;
        if (n !== 128) begin n_fail++; $display("FAIL save_count: got %0d bytes expected 128 (cycles %0d)", n, cyc); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dcnt1 - d0 !== 1) begin n_fail++; $display("FAIL save_done: got %0d pulses expected 1", dcnt1 - d0); end
    endtask

    task automatic test_save_ready_high();
        run_save1(1'b0, 1'b0);
    endtask

    task automatic test_save_random_ready();
        run_save1(1'b1, 1'b0);
    endtask

    task automatic test_load_match();
        int n, cyc, w0, d0;
        bit prev_we;
        w0 = wcnt1; d0 = dcnt1; sl1 = 1'b1;
        @(negedge clk);
        sl1 = 1'b0; n = 0; cyc = 0; prev_we = 0;
        while (!done1 && cyc < 3000) begin
            bus1.si_valid = (n < 128) && ($urandom_range(0, 9) < 7);
            bus1.si_data  = (n == 0) ? 8'h18 : 8'(256 - n);
            n_checks++;
            if (bus1.sst_we && (prev_we || bus1.si_ready)) begin
                n_fail++; $display("FAIL we_pulse: we=%b prev=%b si_ready=%b", bus1.sst_we, prev_we, bus1.si_ready);
            end
            prev_we = bus1.sst_we;
            if (bus1.si_valid && bus1.si_ready) n++;
            @(negedge clk);
            cyc++;
        end
        bus1.si_valid = 1'b0;
        n_checks++;
        if (n !== 128) begin n_fail++; $display("FAIL load_consumed: got %0d expected 128", n); end
        n_checks++;
        if (err1 !== 1'b0) begin n_fail++; $display("FAIL load_err: got %b expected 0", err1); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wcnt1 - w0 !== 127) begin n_fail++; $display("FAIL load_we_count: got %0d expected 127", wcnt1 - w0); end
        n_checks++;
        if (dcnt1 - d0 !== 1) begin n_fail++; $display("FAIL load_done: got %0d expected 1", dcnt1 - d0); end
        for (int k = 0; k < 127; k++) begin
            n_checks++;
            if (mem[k] !== 8'(255 - k)) begin n_fail++; $display("FAIL load_mem[%0d]: got %h expected %h", k, mem[k], 8'(255 - k)); end
        end
    endtask

    task automatic test_load_mismatch();
        int n, cyc, w0, d0;
        w0 = wcnt1; d0 = dcnt1; sl1 = 1'b1;
        @(negedge clk);
        sl1 = 1'b0; n = 0; cyc = 0;
        while (!done1 && cyc < 200) begin
            bus1.si_valid = 1'b1;
            bus1.si_data  = (n == 0) ? 8'h17 : 8'h00;
            if (bus1.si_ready) n++;
            @(negedge clk);
            cyc++;
        end
        bus1.si_valid = 1'b0;
        n_checks++;
        if (err1 !== 1'b1) begin n_fail++; $display("FAIL mismatch_err: got %b expected 1", err1); end
        n_checks++;
        if (n !== 1) begin n_fail++; $display("FAIL mismatch_consumed: got %0d expected 1", n); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (wcnt1 - w0 !== 0) begin n_fail++; $display("FAIL mismatch_we: got %0d expected 0", wcnt1 - w0); end
        n_checks++;
        if (dcnt1 - d0 !== 1) begin n_fail++; $display("FAIL mismatch_done: got %0d expected 1", dcnt1 - d0); end
        n_checks++;
        if (err1 !== 1'b1) begin n_fail++; $display("FAIL mismatch_err_hold: got %b expected 1", err1); end
    endtask

    task automatic test_simultaneous_start();
        run_save1(1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_save();
        int n, cyc, w0, d0;
        w0 = wcnt1; d0 = dcnt1; ss1 = 1'b1; bus1.so_ready = 1'b1;
        @(negedge clk);
        ss1 = 1'b0; n = 0; cyc = 0;
        while (n < 40 && cyc < 1000) begin
            if (bus1.so_valid) n++;
            @(negedge clk);
            cyc++;
        end
        bus1.so_ready = 1'b0;
        while (!bus1.so_valid && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (bus1.so_data !== 8'h7D) begin n_fail++; $display("FAIL byte40: got %h expected 7d (valid=%b)", bus1.so_data, bus1.so_valid); end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus1.sst_addr, bus1.sst_dato, bus1.sst_we, bus1.sst_act, bus1.so_data, bus1.so_valid,
             bus1.si_ready, busy1, done1, err1} !== '0) begin
            n_fail++; $display("FAIL reset_mid: outputs not zero (busy=%b valid=%b data=%h)", busy1, bus1.so_valid, bus1.so_data);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dcnt1 - d0 !== 0 || wcnt1 - w0 !== 0) begin
            n_fail++; $display("FAIL reset_mid_pulses: done %0d we %0d expected 0 0", dcnt1 - d0, wcnt1 - w0);
        end
        run_save1(1'b0, 1'b0);
    endtask

    task automatic test_rd_lat3();
        int n, cyc, gap, d0;
        logic [7:0] exp_b;
        d0 = dcnt3; bus3.so_ready = 1'b1; ss3 = 1'b1;
        @(negedge clk);
        ss3 = 1'b0; n = 0; cyc = 0; gap = 0;
        while (!done3 && cyc < 500) begin
            if (bus3.so_valid) begin
                exp_b = (n == 0) ? 8'h18 : (8'(n - 1) ^ 8'h5A);
                n_checks++;
                if (bus3.so_data !== exp_b) begin n_fail++; $display("FAIL lat3_byte[%0d]: got %h expected %h", n, bus3.so_data, exp_b); end
                if (n > 0) begin
                    n_checks++;
                    if (gap !== 4) begin n_fail++; $display("FAIL lat3_gap[%0d]: got %0d expected 4", n, gap); end
                end
                n++; gap = 0;
            end else begin
                gap++;
            end
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (n !== 5) begin n_fail++; $display("FAIL lat3_count: got %0d expected 5", n); end
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (dcnt3 - d0 !== 1) begin n_fail++; $display("FAIL lat3_done: got %0d expected 1", dcnt3 - d0); end
    endtask

    initial begin
        bus1.so_ready = 1'b0; bus1.si_valid = 1'b0; bus1.si_data = 8'h00;
        bus3.so_ready = 1'b0; bus3.si_valid = 1'b0; bus3.si_data = 8'h00;
        test_reset();
        test_save_ready_high();
        test_save_random_ready();
        test_load_match();
        test_load_mismatch();
        test_simultaneous_start();
        test_reset_mid_save();
        test_rd_lat3();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/map_sst_ctrl.md
MAP_SST_CTRL -- requirements
Module: map_sst_ctrl

Interface
REQ-001 Parameter REG_CNT, default 127: number of mapper save-state registers at sst addresses 0..REG_CNT-1; address REG_CNT returns the mapper index.
REQ-002 Parameter RD_LAT, default 1, range 1..3: cycles from sst_addr change to a valid sst_di.
REQ-003 clk  in  1  system clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start_save  in  1  one-cycle request to dump mapper state; sampled only in IDLE.
REQ-006 start_load  in  1  one-cycle request to restore mapper state; sampled only in IDLE.
REQ-007 exp_map_idx  in  8  mapper index of the currently loaded mapper.
REQ-008 sst_addr  out  8  register address presented to the mapper.
REQ-009 sst_dato  out  8  write data presented to the mapper.
REQ-010 sst_we  out  1  one-cycle mapper register write strobe.
REQ-011 sst_act  out  1  high while the mapper bus is owned for save or load.
REQ-012 sst_di  in  8  mapper readback data for sst_addr.
REQ-013 so_data  out  8 / so_valid  out  1 / so_ready  in  1  save byte stream.
REQ-014 si_data  in  8 / si_valid  in  1 / si_ready  out  1  load byte stream.
REQ-015 busy  out  1 / done  out  1 / err  out  1  status.

Function
REQ-016 The FSM states SHALL be IDLE, S_ADDR, S_WAIT, S_OUT, L_HDR, L_DATA, L_WR and FIN.
REQ-017 The stream format SHALL be byte 0 = mapper index, followed by bytes 1..REG_CNT = registers 0..REG_CNT-1, for REG_CNT+1 bytes in total.
REQ-018 Save sequence:
- IDLE plus start_save -> S_ADDR, with the internal index at REG_CNT.
- S_ADDR drives sst_addr = index, then S_WAIT counts RD_LAT cycles.
- sst_di is captured into so_data, then S_OUT.
REQ-019 S_OUT SHALL assert so_valid and hold so_data stable until so_valid and so_ready are both high.
- On handshake: the index becomes 0 after REG_CNT, otherwise it increments.
- After the byte for register REG_CNT-1, the FSM goes to FIN.
REQ-020 so_valid SHALL NOT fall without a handshake, and a new byte SHALL appear no earlier than RD_LAT+1 cycles after the previous handshake.
REQ-021 L_HDR SHALL assert si_ready and, on handshake, compare si_data with exp_map_idx.
- Mismatch: set err and go to FIN with no sst_we issued.
- Match: go to L_DATA with the index at 0.
REQ-022 L_DATA SHALL assert si_ready and, on handshake, latch si_data into sst_dato and go to L_WR.
REQ-023 L_WR SHALL:
- deassert si_ready;
- pulse sst_we for exactly one cycle with sst_addr = index;
- then increment the index and return to L_DATA, or go to FIN after index REG_CNT-1.
REQ-024 si_ready SHALL be high only in L_HDR and L_DATA; input bytes are accepted only on si_valid and si_ready both high.
REQ-025 FIN SHALL pulse done for one cycle and return to IDLE; err remains set until the next accepted start.
REQ-026 busy and sst_act SHALL be high in every state except IDLE.
REQ-027 Simultaneous start_save and start_load in IDLE SHALL start save; start pulses outside IDLE are ignored.
REQ-028 The index counter SHALL be 8 bits; REG_CNT+1 is required to be at most 256.

Reset
REQ-029 rst SHALL immediately force IDLE and zero the index, sst_addr, sst_dato, so_data, and all strobes and flags (sst_we, sst_act, so_valid, si_ready, busy, done, err).
REQ-030 rst mid-operation SHALL abandon the transfer with no further sst_we or stream handshake, and SHALL NOT pulse done.

Verification
REQ-031 Save, REG_CNT=127, RD_LAT=1, so_ready held high, mapper model returns addr^0x5A and index 24 at addr 127:
- required stream: 128 bytes 0x18, 0x5A, 0x5B, ... in order;
- done asserts exactly once.
REQ-032 Save with so_ready toggling randomly (~30%): byte sequence is identical to REQ-031, and so_data never changes while so_valid is high without a handshake.
REQ-033 Load with exp_map_idx=24, stream 0x18 followed by bytes k=0..126 with value 0xFF-k:
- 127 sst_we pulses;
- addr k receives 0xFF-k;
- err=0, done pulse.
REQ-034 Load with header 0x17 and exp_map_idx=24: err=1, zero sst_we pulses, exactly 1 input byte consumed, done pulse.
REQ-035 rst asserted during S_OUT at byte 40: all outputs zero in the same cycle; a following start_save restarts at the header byte.
REQ-036 start_save and start_load asserted together in IDLE: save runs, si_ready never asserts; RD_LAT=3 variant shows sst_di sampled exactly 3 cycles after sst_addr changes.
